// File: rtl/ins_fetch_queue.sv
// Fetch-side instruction queue: issues sequential PC requests under a credit limit and buffers
// in-order responses for decode. Redirect flushes the queue and drains stale in-flight responses.
module ins_fetch_queue #(
   parameter int unsigned    DEPTH    = 4,
   parameter int unsigned    AW       = 32,
   parameter logic [AW-1:0]  RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst,
   output logic          imem_req_valid,
   input  logic          imem_req_ready,
   output logic [AW-1:0] imem_req_addr,
   input  logic          imem_rsp_valid,
   input  logic [31:0]   imem_rsp_data,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   output logic          ins_valid,
   input  logic          ins_ready,
   output logic [31:0]   ins,
   output logic [AW-1:0] ins_pc
);
   localparam int unsigned   PW         = $clog2(DEPTH);
   localparam int unsigned   CW         = PW + 1;
   localparam logic [CW:0]   DEPTH_W    = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [AW-1:0] PC_STEP    = AW'(4);
   localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);

   typedef enum logic {StFetch, StDrain} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
   logic [AW-1:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [31:0]     data_q [DEPTH];
   logic [AW-1:0]   pc_q   [DEPTH];

   logic            req_fire;
   logic            enq;
   logic            deq;
   logic            drop;

   // Credits come from registered counters only, so a freed slot is usable next cycle.
   assign imem_req_valid = ~rst & (({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_W);
   assign imem_req_addr  = fetch_pc_q;
   assign ins_valid      = (count_q != '0);
   assign ins            = data_q[head_q];
   assign ins_pc         = pc_q[head_q];

   always_comb begin
      req_fire      = imem_req_valid & imem_req_ready;
      enq           = imem_rsp_valid & (state_q == StFetch) & ~redirect_valid;
      deq           = ins_valid & ins_ready & ~redirect_valid;
      drop          = imem_rsp_valid & (state_q == StDrain) & ~redirect_valid;
      // A request accepted alongside a redirect is still in flight at the memory.
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      count_d       = count_q;
      drop_cnt_d    = drop_cnt_q;
      head_d        = head_q;
      tail_d        = tail_q;

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ALIGN_MASK;
         rsp_pc_d   = redirect_pc & ALIGN_MASK;
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
         drop_cnt_d = outstanding_d;
         state_d    = (outstanding_d != '0) ? StDrain : StFetch;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
         if (enq) begin
            rsp_pc_d = rsp_pc_q + PC_STEP;
            tail_d   = tail_q + PW'(1);
         end
         if (deq) head_d = head_q + PW'(1);
         count_d = count_q + CW'(enq) - CW'(deq);
         if (drop) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
            if (drop_cnt_q == CW'(1)) state_d = StFetch;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StFetch;
         fetch_pc_q    <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         count_q       <= '0;
         drop_cnt_q    <= '0;
         head_q        <= '0;
         tail_q        <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         count_q       <= count_d;
         drop_cnt_q    <= drop_cnt_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else if (enq) begin
         data_q[tail_q] <= imem_rsp_data;
         pc_q[tail_q]   <= rsp_pc_q;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(enq && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Bench for ins_fetch_queue: in-order memory with random latency plus a queue-level model of the
// decode stream, compared every cycle; directed phases pin literal PCs.
module tb_ins_fetch_queue;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        ins_valid;
   logic        ins_ready = 1'b0;
   logic [31:0] ins;
   logic [31:0] ins_pc;

   ins_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ins_valid      (ins_valid),
      .ins_ready      (ins_ready),
      .ins            (ins),
      .ins_pc         (ins_pc)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int unsigned due; bit stale; } req_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;

   req_t        pend[$];
   ent_t        q[$];
   logic [31:0] m_fetch_pc = RESET_PC;
   logic [31:0] seen_pc[$];
   int unsigned n_acc = 0;
   int unsigned cyc = 0;
   int unsigned lat_min = 1;
   int unsigned lat_max = 1;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_seen(input string name, input int idx, input logic [31:0] exp);
      n_vec++;
      if (seen_pc.size() <= idx) begin
         n_err++;
         $display("FAIL %s: only %0d instructions consumed, expected pc %h at index %0d",
                  name, seen_pc.size(), exp, idx);
      end else if (seen_pc[idx] !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, seen_pc[idx], exp);
      end
   endtask

   // Memory model, reference model and per-cycle compare; inputs are stable at the falling edge.
   always @(negedge clk) begin
      bit   exp_rv, fire, rsp;
      req_t r;
      ent_t e;
      cyc++;
      exp_rv = !rst && ((pend.size() + q.size()) < DEPTH);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (!rst) begin
         chk("req_addr", imem_req_addr, m_fetch_pc);
         chk("ins_valid", 32'(ins_valid), 32'(q.size() != 0));
         if (q.size() != 0) begin
            chk("ins", ins, q[0].data);
            chk("ins_pc", ins_pc, q[0].pc);
         end
      end
      rsp = !rst && (pend.size() != 0) && (cyc >= pend[0].due);
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? mem_word(pend[0].addr) : 32'h0;

      if (rst) begin
         pend.delete();
         q.delete();
         m_fetch_pc = RESET_PC;
      end else begin
         fire = imem_req_valid && imem_req_ready;
         if (fire) n_acc++;
         if (ins_valid && ins_ready && !redirect_valid) seen_pc.push_back(ins_pc);
         if (q.size() != 0 && ins_ready && !redirect_valid) void'(q.pop_front());
         if (rsp) begin
            r = pend.pop_front();
            if (!r.stale && !redirect_valid) begin
               e.data = mem_word(r.addr);
               e.pc   = r.addr;
               q.push_back(e);
            end
         end
         if (fire) begin
            r.addr  = imem_req_addr;
            r.due   = cyc + $urandom_range(lat_max, lat_min);
            r.stale = redirect_valid;
            pend.push_back(r);
         end
         if (redirect_valid) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            q.delete();
            m_fetch_pc = redirect_pc & ~32'h3;
         end else if (fire) begin
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
         chk("credit", 32'((pend.size() + q.size()) <= DEPTH), 32'd1);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      n_acc = 0;
      seen_pc.delete();
   endtask

   task automatic pulse_redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      seen_pc.delete();
      tick(1);
      redirect_valid = 1'b0;
   endtask

   initial begin
      // Reset values
      tick(3);
      chk("rst_ins_valid", 32'(ins_valid), 32'd0);
      chk("rst_ins", ins, 32'h0);
      chk("rst_ins_pc", ins_pc, 32'h0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, RESET_PC);

      // Streaming, 1-cycle memory
      imem_req_ready = 1'b1;
      ins_ready      = 1'b1;
      rst            = 1'b0;
      seen_pc.delete();
      tick(20);
      for (int i = 0; i < 6; i++) chk_seen("stream_pc", i, 32'(i * 4));

      // Decode stalled: exactly DEPTH requests, then drain in order
      ins_ready = 1'b0;
      do_reset();
      tick(12);
      chk("stall_req_count", n_acc, 32'd4);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      ins_ready = 1'b1;
      tick(12);
      for (int i = 0; i < 5; i++) chk_seen("stall_drain_pc", i, 32'(i * 4));

      // 3-cycle memory, redirect with stale responses in flight
      lat_min = 3;
      lat_max = 3;
      do_reset();
      tick(6);
      pulse_redirect(32'h0000_0100);
      tick(20);
      chk_seen("redir_pc0", 0, 32'h0000_0100);
      chk_seen("redir_pc1", 1, 32'h0000_0104);
      chk_seen("redir_pc2", 2, 32'h0000_0108);

      // Redirect on a cycle with response, enqueue and dequeue all active
      lat_min = 1;
      lat_max = 1;
      tick(10);
      pulse_redirect(32'h0000_0200);
      chk("flush_ins_valid", 32'(ins_valid), 32'd0);
      tick(10);
      chk_seen("flush_pc0", 0, 32'h0000_0200);

      // Address wrap and low-bit masking
      pulse_redirect(32'hFFFF_FFFC);
      tick(10);
      chk_seen("wrap_pc0", 0, 32'hFFFF_FFFC);
      chk_seen("wrap_pc1", 1, 32'h0000_0000);
      pulse_redirect(32'h0000_0103);
      chk("mask_req_addr", imem_req_addr, 32'h0000_0100);
      tick(10);
      chk_seen("mask_pc0", 0, 32'h0000_0100);

      // Randomized traffic
      lat_min = 1;
      lat_max = 5;
      for (int i = 0; i < 4000; i++) begin
         imem_req_ready = ($urandom_range(3, 0) != 0);
         ins_ready      = ($urandom_range(2, 0) != 0);
         redirect_valid = ($urandom_range(29, 0) == 0);
         redirect_pc    = $urandom;
         rst            = ($urandom_range(599, 0) == 0);
         tick(1);
      end
      rst            = 1'b0;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      ins_ready      = 1'b1;
      tick(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
